tc_spi_read_master: RTL and testbench

Read-only SPI master that sits directly upstream of the thermocouple controller. It clocks one 32-bit frame out of a MAX31855-style thermocouple converter each time the controller requests it. It answers the controller's spi_ena / spi_not_busy handshake and presents the captured word on spi_rx_data. The captured word is held stable until the next frame completes.

---
 rtl/tc_spi_read_master.sv | 163 ++++++++++++++++
 tb/tb_tc_spi_read_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_spi_read_master.sv
// Read-only SPI master (CPOL=0, sample on SCLK rise) that pulls one
// FRAME_BITS-wide word from a MAX31855-style converter per request.
//
// state | meaning
// IDLE  | cs_n high, ready for spi_ena
// SETUP | cs_n low, waiting CS_SETUP cycles before the first SCLK half-period
// SHIFT | generating SCLK, shifting miso_s in on each rising edge
// HOLD  | cs_n high for CS_IDLE cycles before reporting ready again
module tc_spi_read_master #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 32,
  parameter int CS_SETUP   = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_ena,
  output logic                  spi_not_busy,
  output logic [FRAME_BITS-1:0] spi_rx_data,
  output logic                  rx_valid,
  output logic                  sclk,
  output logic                  cs_n,
  input  logic                  miso
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int CNT_MAX = (CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] rx_data_d;
  logic                  sclk_d, cs_n_d, not_busy_d, rx_valid_d;
  logic                  miso_meta, miso_s;

  // Two-flop synchroniser for the asynchronous converter data line.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_s    <= miso_meta;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      spi_rx_data  <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      spi_not_busy <= 1'b1;
      rx_valid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      spi_rx_data  <= rx_data_d;
      sclk         <= sclk_d;
      cs_n         <= cs_n_d;
      spi_not_busy <= not_busy_d;
      rx_valid     <= rx_valid_d;
    end
  end

  // Next-state and next-output decode; all outputs hold unless changed.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    rx_data_d  = spi_rx_data;
    sclk_d     = sclk;
    cs_n_d     = cs_n;
    not_busy_d = spi_not_busy;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cs_n_d     = 1'b1;
        sclk_d     = 1'b0;
        not_busy_d = 1'b1;
        if (spi_ena) begin
          state_d    = SETUP;
          cs_n_d     = 1'b0;
          not_busy_d = 1'b0;
          cnt_d      = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk;
          if (!sclk) begin
            // Rising edge: the slave launched this bit on the previous fall.
            shreg_d = {shreg_q[FRAME_BITS-2:0], miso_s};
            bit_d   = bit_q + 1'b1;
          end else if (bit_q == BIT_LAST) begin
            // Falling edge after the last sample closes the frame.
            sclk_d     = 1'b0;
            cs_n_d     = 1'b1;
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            state_d    = HOLD;
            cnt_d      = '0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        cs_n_d = 1'b1;
        if (cnt_q == IDLE_LAST) begin
          state_d    = IDLE;
          not_busy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        cs_n_d     = 1'b1;
        sclk_d     = 1'b0;
        not_busy_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tc_spi_read_master.sv
// Directed bench for tc_spi_read_master: default-parameter instance for
// frame timing/handshake cases, plus a fast-parameter instance for a sweep.
module tb_tc_spi_read_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena1, nb1, rxv1, sclk1, cs_n1, miso1;
  logic [31:0] data1;
  logic        ena2, nb2, rxv2, sclk2, cs_n2, miso2;
  logic [31:0] data2;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tc_spi_read_master u_dut1 (
    .clk(clk), .rst(rst), .spi_ena(ena1), .spi_not_busy(nb1),
    .spi_rx_data(data1), .rx_valid(rxv1), .sclk(sclk1), .cs_n(cs_n1),
    .miso(miso1)
  );

  tc_spi_read_master #(.CLK_DIV(3), .FRAME_BITS(32), .CS_SETUP(1), .CS_IDLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .spi_ena(ena2), .spi_not_busy(nb2),
    .spi_rx_data(data2), .rx_valid(rxv2), .sclk(sclk2), .cs_n(cs_n2),
    .miso(miso2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rx1(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rxv1 && n < 400);
    chk(tag, {31'd0, rxv1}, 32'd1);
  endtask

  // Converter models: D31 on cs_n fall, next bit after every SCLK fall.
  logic [31:0] tx1 = '0, sh1 = '0, tx2 = '0, sh2 = '0;
  logic        s_cs1 = 1'b1, s_cs2 = 1'b1;
  initial begin miso1 = 1'b0; miso2 = 1'b0; end

  always @(cs_n1 or negedge sclk1) begin
    if (cs_n1) s_cs1 = 1'b1;
    else if (s_cs1) begin s_cs1 = 1'b0; sh1 = tx1; end
    else sh1 = {sh1[30:0], 1'b0};
    miso1 = sh1[31];
  end

  always @(cs_n2 or negedge sclk2) begin
    if (cs_n2) s_cs2 = 1'b1;
    else if (s_cs2) begin s_cs2 = 1'b0; sh2 = tx2; end
    else sh2 = {sh2[30:0], 1'b0};
    miso2 = sh2[31];
  end

  // Timing observer for the default instance, sampled on the falling clk edge.
  int cs_run = 0, hi_run = 0, nb_run = 0, since_rise = 0;
  int last_cs_len = 0, last_hi_len = 0, last_nb_len = 0;
  int frame_rises = 0, per_min = 9999, per_max = 0;
  int rx_cnt = 0, glitch = 0, rx_cs_ok = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_nb = 1'b1;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!cs_n1) begin
      if (prev_cs) begin
        last_hi_len = hi_run;
        cs_run = 0;
        frame_rises = 0;
        per_min = 9999;
        per_max = 0;
      end
      cs_run++;
    end else begin
      if (!prev_cs) begin
        last_cs_len = cs_run;
        hi_run = 0;
      end
      hi_run++;
    end
    if (!nb1) nb_run++;
    else if (!prev_nb) begin
      last_nb_len = nb_run;
      nb_run = 0;
    end
    since_rise++;
    if (sclk1 && !prev_sclk) begin
      if (frame_rises > 0) begin
        if (since_rise < per_min) per_min = since_rise;
        if (since_rise > per_max) per_max = since_rise;
      end
      since_rise = 0;
      frame_rises++;
    end
    if (rxv1) begin
      rx_cnt++;
      rx_cs_ok = (cs_n1 && !prev_cs) ? 1 : 0;
    end
    if (!rst && !rxv1 && data1 != prev_data) glitch++;
    prev_cs = cs_n1;
    prev_sclk = sclk1;
    prev_nb = nb1;
    prev_data = data1;
  end

  initial begin
    int base, rises, n, len;
    rst = 1'b1; ena1 = 1'b0; ena2 = 1'b0;
    wait_cyc(3);
    rst = 1'b0;

    // Reset then idle.
    wait_cyc(50);
    #1;
    chk("idle_nb", {31'd0, nb1}, 32'd1);
    chk("idle_cs", {31'd0, cs_n1}, 32'd1);
    chk("idle_sclk", {31'd0, sclk1}, 32'd0);
    chk("idle_data", data1, 32'd0);
    chk("idle_rx_cnt", rx_cnt, 32'd0);

    // Single frame from a one-cycle request.
    tx1 = 32'h1234_5678;
    @(negedge clk); ena1 = 1'b1;
    @(negedge clk); ena1 = 1'b0;
    chk("single_nb_fall", {31'd0, nb1}, 32'd0);
    chk("single_cs_fall", {31'd0, cs_n1}, 32'd0);
    wait_rx1("single_rx_timeout");
    chk("single_data", data1, 32'h1234_5678);
    wait_cyc(10);
    #1;
    chk("single_cs_len", last_cs_len, 32'd258);
    chk("single_nb_len", last_nb_len, 32'd262);
    chk("single_rises", frame_rises, 32'd32);
    chk("single_per_min", per_min, 32'd8);
    chk("single_per_max", per_max, 32'd8);
    chk("single_rx_cnt", rx_cnt, 32'd1);
    chk("single_rx_at_cs_rise", rx_cs_ok, 32'd1);

    // Controller-style handshake: drop the request once busy is seen.
    tx1 = 32'hFFFF_0007;
    base = rx_cnt;
    ena1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (nb1 && n < 10);
    ena1 = 1'b0;
    chk("hs_nb_drop", {31'd0, nb1}, 32'd0);
    wait_rx1("hs_rx_timeout");
    chk("hs_data", data1, 32'hFFFF_0007);
    wait_cyc(300);
    #1;
    chk("hs_data_stable", data1, 32'hFFFF_0007);
    chk("hs_one_frame", rx_cnt - base, 32'd1);
    chk("hs_cs_idle", {31'd0, cs_n1}, 32'd1);

    // Back-to-back frames with the request held high.
    tx1 = 32'hAAAA_5555;
    base = rx_cnt;
    ena1 = 1'b1;
    wait_rx1("b2b_rx1_timeout");
    chk("b2b_data1", data1, 32'hAAAA_5555);
    tx1 = 32'h0000_0001;
    wait_rx1("b2b_rx2_timeout");
    ena1 = 1'b0;
    chk("b2b_data2", data1, 32'h0000_0001);
    wait_cyc(10);
    #1;
    chk("b2b_cs_gap", last_hi_len, 32'd5);
    chk("b2b_two_frames", rx_cnt - base, 32'd2);
    chk("no_partial_update", glitch, 32'd0);

    // Reset at the 16th rising SCLK edge of a frame.
    tx1 = 32'hDEAD_BEEF;
    @(negedge clk); ena1 = 1'b1;
    @(negedge clk); ena1 = 1'b0;
    rises = 0;
    n = 0;
    while (rises < 16 && n < 400) begin
      logic ps;
      ps = sclk1;
      @(negedge clk);
      n++;
      if (sclk1 && !ps) rises++;
    end
    chk("rst_mid_reach16", rises, 32'd16);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs", {31'd0, cs_n1}, 32'd1);
    chk("rst_mid_sclk", {31'd0, sclk1}, 32'd0);
    chk("rst_mid_nb", {31'd0, nb1}, 32'd1);
    chk("rst_mid_data", data1, 32'd0);
    chk("rst_mid_rxv", {31'd0, rxv1}, 32'd0);
    rst = 1'b0;
    base = rx_cnt;
    wait_cyc(20);
    #1;
    chk("rst_mid_no_rx", rx_cnt - base, 32'd0);
    tx1 = 32'h0123_4567;
    @(negedge clk); ena1 = 1'b1;
    @(negedge clk); ena1 = 1'b0;
    wait_rx1("post_rst_rx_timeout");
    chk("post_rst_data", data1, 32'h0123_4567);

    // Fast-parameter instance with random words.
    for (int i = 0; i < 100; i++) begin
      tx2 = $urandom;
      @(negedge clk); ena2 = 1'b1;
      @(negedge clk); ena2 = 1'b0;
      len = 0;
      n = 0;
      while (!rxv2 && n < 400) begin
        if (!cs_n2) len++;
        @(negedge clk);
        n++;
      end
      chk("sweep_data", data2, tx2);
      chk("sweep_cs_len", len, 32'd193);
      n = 0;
      while (!nb2 && n < 10) begin
        @(negedge clk);
        n++;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
